bus_arbiter_rr: RTL and testbench

Round-robin arbiter sharing the single gpiomem port between up to N bus masters (cores, a future DMA or debug master). Each master uses the same request/grant level handshake the cores already drive. The arbiter adds fair rotation, a bounded hold time with forced revocation, and per-master timeout status. It sits between the masters and gpiomem and drives gpiomem's `rw_select`, `address` and `data_in` ports.

---
 rtl/arbiter_pkg.sv | 24 ++
 rtl/bus_arbiter_rr_pick.sv | 30 +++
 rtl/bus_arbiter_rr.sv | 129 ++++++++++++
 tb/tb_bus_arbiter_rr.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the gpiomem round-robin arbiter.
// FSM state encoding, default widths, one-hot index conversion.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_t;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  // OR of set-bit positions; exact for one-hot or zero input
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority encoder: first eligible master after `last`.
// Scan order is last+1, last+2, ... wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner_idx,
  output logic          any
);

  int w_j;

  // walk the ring once, latch the first hit
  always_comb begin
    winner_idx = '0;
    any        = 1'b0;
    w_j        = 0;
    for (int i = 1; i <= N; i++) begin
      w_j = int'(last) + i;
      if (w_j >= N) w_j = w_j - N;
      if (!any && eligible[w_j]) begin
        any        = 1'b1;
        winner_idx = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing the gpiomem port among N masters.
// Bounded hold with forced revocation, mask until req drops, sticky flags.
module bus_arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 64,
  localparam int OW      = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        grant,
  input  logic [N-1:0]        rw_in,
  input  logic [N*ADDR_W-1:0] addr_in,
  input  logic [N*DATA_W-1:0] wdata_in,
  output logic [N*DATA_W-1:0] rdata_out,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [OW-1:0]       owner,
  output logic                busy,
  output logic [N-1:0]        timeout_flags,
  input  logic                clr_flags
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_t     r_state;
  logic [N-1:0]   r_grant;
  logic           r_busy;
  logic [OW-1:0]  r_last;
  logic [HW-1:0]  r_hold;
  logic [N-1:0]   r_mask;
  logic [N-1:0]   r_flags;

  logic [OW-1:0]  w_owner;
  logic [OW-1:0]  w_win;
  logic           w_any;
  logic [N-1:0]   w_elig;
  logic           w_revoke;
  logic [N-1:0]   w_revoke_vec;
  logic [N-1:0]   w_win_oh;

  assign w_owner  = OW'(onehot_to_idx(8'(r_grant)));
  assign w_elig   = req & ~r_mask;
  assign w_win_oh = {{(N-1){1'b0}}, 1'b1} << w_win;

  assign w_revoke = (r_state == GRANT) && req[w_owner]
                 && (MAX_HOLD != 0)
                 && (r_hold == HW'(HOLD_LAST));
  assign w_revoke_vec = w_revoke ? r_grant : '0;

  rr_pick #(.N(N)) u_pick (
    .eligible   (w_elig),
    .last       (r_last),
    .winner_idx (w_win),
    .any        (w_any)
  );

  // grant FSM: pick, hold with counter, one turnaround cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_last  <= OW'(N - 1);
      r_hold  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_win_oh;
            r_busy  <= 1'b1;
            r_hold  <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[w_owner] || w_revoke) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= w_owner;
            r_state <= RELEASE;
          end else if (r_hold < HW'(HOLD_LAST)) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        RELEASE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // mask drops once req drops; flag set beats clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mask  <= '0;
      r_flags <= '0;
    end else begin
      r_mask  <= (r_mask & req) | w_revoke_vec;
      r_flags <= (clr_flags ? '0 : r_flags) | w_revoke_vec;
    end
  end

  // owner's bus to gpiomem; idle drives a harmless read of 0
  always_comb begin
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata_out = '0;
    if (r_busy) begin
      mem_rw    = rw_in[w_owner];
      mem_addr  = addr_in[w_owner*ADDR_W +: ADDR_W];
      mem_wdata = wdata_in[w_owner*DATA_W +: DATA_W];
      rdata_out[w_owner*DATA_W +: DATA_W] = mem_rdata;
    end
  end

  assign grant         = r_grant;
  assign busy          = r_busy;
  assign owner         = w_owner;
  assign timeout_flags = r_flags;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: vector table for arbitration,
// hand sequences for mux, read path and mid-grant reset.
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 9;
  localparam int DW = 8;
  localparam int MH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic [N-1:0]    rw_in;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] wdata_in;
  logic [N*DW-1:0] rdata_out;
  logic            mem_rw;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [1:0]      owner;
  logic            busy;
  logic [N-1:0]    timeout_flags;
  logic            clr_flags;

  always #5 clk = ~clk;

  bus_arbiter_rr #(
    .N(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .grant         (grant),
    .rw_in         (rw_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .rdata_out     (rdata_out),
    .mem_rw        (mem_rw),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .owner         (owner),
    .busy          (busy),
    .timeout_flags (timeout_flags),
    .clr_flags     (clr_flags)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       clr;
    logic [3:0] g;
    logic [3:0] f;
  } vec_t;

  vec_t tbl[64];
  int   nv;
  int   checks;
  int   errors;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] rq,
                     input logic clr, input logic [3:0] g,
                     input logic [3:0] f);
    tbl[nv].rst = rst;
    tbl[nv].req = rq;
    tbl[nv].clr = clr;
    tbl[nv].g   = g;
    tbl[nv].f   = f;
    nv++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] eo;
    checks   = 0;
    errors   = 0;
    nv       = 0;
    reset    = 1'b0;
    req      = '0;
    rw_in    = '0;
    addr_in  = '0;
    wdata_in = '0;
    mem_rdata = '0;
    clr_flags = 1'b0;

    // two-master start, drop and handoff
    add(0, 4'b0011, 0, 4'b0001, 0);
    add(0, 4'b0010, 0, 4'b0000, 0);
    add(0, 4'b0010, 0, 4'b0000, 0);
    add(0, 4'b0010, 0, 4'b0010, 0);
    add(0, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 0);
    // full rotation, 3-cycle holds
    add(1, 4'b0000, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 3; h++)
        add(0, 4'hF, 0, 4'(1 << k), 0);
      add(0, 4'hF & ~4'(1 << k), 0, 4'b0000, 0);
      add(0, 4'hF, 0, 4'b0000, 0);
    end
    add(0, 4'hF, 0, 4'b0001, 0);
    add(0, 4'h0, 0, 4'b0000, 0);
    add(0, 4'h0, 0, 4'b0000, 0);
    // forced revocation of master 2
    add(1, 4'b0000, 0, 4'b0000, 0);
    for (int h = 0; h < MH; h++)
      add(0, 4'b0100, 0, 4'b0100, 0);
    add(0, 4'b0100, 0, 4'b0000, 4'b0100);
    add(0, 4'b0100, 0, 4'b0000, 4'b0100);
    add(0, 4'b0100, 0, 4'b0000, 4'b0100);
    add(0, 4'b0100, 0, 4'b0000, 4'b0100);
    add(0, 4'b0000, 0, 4'b0000, 4'b0100);
    add(0, 4'b0100, 0, 4'b0100, 4'b0100);
    add(0, 4'b0100, 1, 4'b0100, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000);

    // reset state
    step();
    step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_flags", 32'(timeout_flags), 32'h0);
    chk("rst_mem_rw", 32'(mem_rw), 32'h0);
    reset = 1'b1;

    for (int v = 0; v < nv; v++) begin
      reset     = tbl[v].rst ? 1'b0 : 1'b1;
      req       = tbl[v].req;
      clr_flags = tbl[v].clr;
      step();
      chk($sformatf("v%0d_grant", v), 32'(grant), 32'(tbl[v].g));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'(|tbl[v].g));
      chk($sformatf("v%0d_flags", v), 32'(timeout_flags), 32'(tbl[v].f));
      if (tbl[v].g != 4'b0000) begin
        eo = 2'd0;
        for (int b = 0; b < 4; b++)
          if (tbl[v].g[b]) eo = 2'(b);
        chk($sformatf("v%0d_owner", v), 32'(owner), 32'(eo));
      end
    end
    reset     = 1'b1;
    clr_flags = 1'b0;

    // write through master 1, master 3 also drives rw
    rw_in = 4'b1010;
    addr_in[0*AW +: AW]  = 9'h0AA;
    addr_in[1*AW +: AW]  = 9'h105;
    addr_in[3*AW +: AW]  = 9'h1FF;
    wdata_in[1*DW +: DW] = 8'hA5;
    wdata_in[3*DW +: DW] = 8'hFF;
    mem_rdata = 8'h77;
    req = 4'b0010;
    step();
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_mem_rw", 32'(mem_rw), 32'h1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h105);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    chk("wr_rdata", 32'(rdata_out), 32'h0000_7700);
    req = 4'b0000;
    step();
    chk("idle_mem_rw", 32'(mem_rw), 32'h0);
    chk("idle_mem_addr", 32'(mem_addr), 32'h0);
    chk("idle_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("idle_rdata", 32'(rdata_out), 32'h0);
    step();

    // read through master 0
    rw_in[0]  = 1'b0;
    mem_rdata = 8'h3C;
    req = 4'b0001;
    step();
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_mem_rw", 32'(mem_rw), 32'h0);
    chk("rd_mem_addr", 32'(mem_addr), 32'h0AA);
    chk("rd_rdata", 32'(rdata_out), 32'h0000_003C);
    req = 4'b0000;
    step();
    step();

    // reset lands while master 1 is writing
    req = 4'b0010;
    step();
    chk("pre_rst_grant", 32'(grant), 32'h2);
    chk("pre_rst_mem_rw", 32'(mem_rw), 32'h1);
    reset = 1'b0;
    step();
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_mem_rw", 32'(mem_rw), 32'h0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_owner", 32'(owner), 32'h0);
    chk("mid_rst_flags", 32'(timeout_flags), 32'h0);
    reset = 1'b1;
    req = 4'b0011;
    step();
    chk("post_rst_grant", 32'(grant), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
